// File: rtl/seg_pkg.sv
// Shared 7-segment constants and hex glyph table (active-high, bit 6 = a).
// Pure definitions; no timing or flow control.
package seg_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_OFF;
    case (nib)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-high 7-segment glyph; zero latency, no backpressure.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex7(nibble);

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed N-digit 7-segment scan driver with PWM, blanking, lz suppression and frame-synced double buffer.
// Pins registered, 1-cycle latency from cnt/idx; load is always accepted (no backpressure).
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int TICK_DIV    = 50000,
  parameter int PWM_W       = 3,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   nibbles,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  input  logic [PWM_W-1:0]      brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_start,
  output logic                  pending
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int OW = CW + PWM_W + 1;

  localparam logic [6:0]        SEG_IDLE = (SEG_ACT_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic              DP_IDLE  = (SEG_ACT_LOW != 0);
  localparam logic [DIGITS-1:0] DIG_IDLE = (DIG_ACT_LOW != 0) ? '1 : '0;

  typedef struct packed {
    logic [PWM_W-1:0]    bright;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   dpv;
    logic [4*DIGITS-1:0] nib;
  } frame_t;

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              wrap;
  frame_t            shadow;
  frame_t            active;
  logic [OW-1:0]     on_len;
  logic              pwm_on;
  logic              lz_run;
  logic [DIGITS-1:0] supp;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic              cur_supp;
  logic              lit;
  logic [6:0]        dec_seg;
  logic [6:0]        seg_hi;
  logic              dp_hi;
  logic [DIGITS-1:0] dig_hi;

  assign tick = (cnt == CW'(TICK_DIV - 1));
  assign wrap = tick & (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + CW'(1);
      frame_start <= wrap;
      if (tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  // Swap reads the pre-load shadow, so a load on the wrap cycle lands one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (wrap) active <= shadow;
      if (load) begin
        shadow  <= '{bright: brightness, blank: blank_in, dpv: dp_in, nib: nibbles};
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  assign on_len = ((OW'(active.bright) + OW'(1)) * OW'(TICK_DIV)) >> PWM_W;
  assign pwm_on = (OW'(cnt) < on_len);

  // Walk from the most significant digit down; suppression stops at the first non-zero nibble.
  always_comb begin
    lz_run = 1'b1;
    supp   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run  = lz_run & (active.nib[4*i +: 4] == 4'h0);
      supp[i] = lz_en & lz_run & (i != 0);
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = active.nib[4*i +: 4];
        cur_dp    = active.dpv[i];
        cur_blank = active.blank[i];
        cur_supp  = supp[i];
      end
    end
  end

  seg_hex_decoder u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  assign lit    = pwm_on & ~cur_blank & ~cur_supp;
  assign seg_hi = lit ? dec_seg : SEG_OFF;
  assign dp_hi  = lit & cur_dp;
  assign dig_hi = lit ? (DIGITS'(1) << idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_IDLE;
      dp  <= DP_IDLE;
      dig <= DIG_IDLE;
    end else begin
      seg <= (SEG_ACT_LOW != 0) ? ~seg_hi : seg_hi;
      dp  <= (SEG_ACT_LOW != 0) ? ~dp_hi : dp_hi;
      dig <= (DIG_ACT_LOW != 0) ? ~dig_hi : dig_hi;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed scenarios plus a random run against a frame-level reference model.
module tb_seg_scan_mux;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 8;
  localparam int PWM_W    = 3;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] nibbles;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic [2:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig;
  logic        frame_start;
  logic        pending;

  int tests_run;
  int tests_failed;

  seg_scan_mux #(
    .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .PWM_W(PWM_W), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .nibbles(nibbles), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .brightness(brightness), .seg(seg), .dp(dp),
    .dig(dig), .frame_start(frame_start), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position in the frame plus shadow/active frame contents.
  logic [6:0]  hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  int          m_cnt, m_idx;
  logic [15:0] s_nib, a_nib;
  logic [3:0]  s_dp, a_dp, s_blank, a_blank;
  logic [2:0]  s_br, a_br;
  logic        m_pend;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dig;
  logic        e_fs;
  logic        e_pend;
  int          mcnt [4];
  logic [6:0]  mseg [4];

  function automatic int fpos();
    return m_idx * TICK_DIV + m_cnt;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_pend = 1'b0;
    s_nib = '0; a_nib = '0; s_dp = '0; a_dp = '0;
    s_blank = '0; a_blank = '0; s_br = '0; a_br = '0;
  endtask

  // Predict the pins one edge ahead, advance the model, then clock the DUT.
  task automatic step();
    int hi, on_len;
    bit lit, wrap;
    logic [3:0] oh;
    hi = -1;
    for (int i = 0; i < DIGITS; i++) if (a_nib[4*i +: 4] != 4'h0) hi = i;
    on_len = ((int'(a_br) + 1) * TICK_DIV) / (1 << PWM_W);
    lit = (m_cnt < on_len) && !a_blank[m_idx] && !(lz_en && m_idx > 0 && m_idx > hi);
    oh = 4'b0001 << m_idx;
    if (lit) begin
      e_seg = ~hex_tab[a_nib[4*m_idx +: 4]];
      e_dp  = ~a_dp[m_idx];
      e_dig = ~oh;
    end else begin
      e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF;
    end
    wrap = (m_cnt == TICK_DIV - 1) && (m_idx == DIGITS - 1);
    e_fs = wrap;
    if (wrap) begin
      a_nib = s_nib; a_dp = s_dp; a_blank = s_blank; a_br = s_br;
    end
    if (load) begin
      s_nib = nibbles; s_dp = dp_in; s_blank = blank_in; s_br = brightness; m_pend = 1'b1;
    end else if (wrap) begin
      m_pend = 1'b0;
    end
    e_pend = m_pend;
    if (m_cnt == TICK_DIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % DIGITS;
    end else begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic next_frame();
    step();
    for (int k = 0; k < 64 && fpos() != 0; k++) step();
  endtask

  task automatic run_to(input int pos);
    for (int k = 0; k < 64 && fpos() != pos; k++) step();
  endtask

  // Observe one full frame from position 0; optionally pulse load at load_pos.
  task automatic measure_frame(input int load_pos);
    logic [3:0] oh;
    for (int d = 0; d < 4; d++) begin mcnt[d] = 0; mseg[d] = 7'h7F; end
    for (int k = 0; k < DIGITS * TICK_DIV; k++) begin
      load = (k == load_pos);
      step();
      load = 1'b0;
      for (int d = 0; d < 4; d++) begin
        oh = 4'b0001 << d;
        if (dig === ~oh) begin mcnt[d]++; mseg[d] = seg; end
      end
    end
  endtask

  task automatic load_now();
    load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (dig !== 4'hF) begin tests_failed++; $display("FAIL reset_dig got %h want F", dig); end
    tests_run++; if (seg !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg got %h want 7F", seg); end
    tests_run++; if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_fs got %b want 0", frame_start); end
    rst_n = 1'b1;
    model_reset();
    nibbles = 16'h8888; brightness = 3'd7; load_now();
    next_frame();
    nibbles = 16'h1111; load_now();
    step(); step();
    tests_run++; if (dig !== 4'hE) begin tests_failed++; $display("FAIL prereset_dig got %h want E", dig); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (dig !== 4'hF) begin tests_failed++; $display("FAIL async_dig got %h want F", dig); end
    tests_run++; if (seg !== 7'h7F) begin tests_failed++; $display("FAIL async_seg got %h want 7F", seg); end
    tests_run++; if (dp !== 1'b1) begin tests_failed++; $display("FAIL async_dp got %b want 1", dp); end
    tests_run++; if (pending !== 1'b0) begin tests_failed++; $display("FAIL async_pending got %b want 0", pending); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step();
    tests_run++; if (seg !== 7'h01) begin tests_failed++; $display("FAIL release_seg got %h want 01", seg); end
    tests_run++; if (dig !== 4'hE) begin tests_failed++; $display("FAIL release_dig got %h want E", dig); end
    tests_run++; if (dp !== 1'b1) begin tests_failed++; $display("FAIL release_dp got %b want 1", dp); end
  endtask

  task automatic test_load_frame();
    nibbles = 16'h5555; brightness = 3'd7; load_now();
    next_frame();
    run_to(5);
    nibbles = 16'h12AF; load_now();
    tests_run++; if (pending !== 1'b1) begin tests_failed++; $display("FAIL load_pending got %b want 1", pending); end
    tests_run++; if (seg !== 7'h24) begin tests_failed++; $display("FAIL midframe_seg got %h want 24", seg); end
    next_frame();
    tests_run++; if (pending !== 1'b0) begin tests_failed++; $display("FAIL wrap_pending got %b want 0", pending); end
    measure_frame(-1);
    tests_run++; if (mseg[0] !== 7'h38) begin tests_failed++; $display("FAIL frame_dig0 got %h want 38", mseg[0]); end
    tests_run++; if (mseg[3] !== 7'h4F) begin tests_failed++; $display("FAIL frame_dig3 got %h want 4F", mseg[3]); end
  endtask

  task automatic test_lz();
    lz_en = 1'b1;
    nibbles = 16'h0050; load_now();
    next_frame();
    measure_frame(-1);
    tests_run++; if (mcnt[3] !== 0) begin tests_failed++; $display("FAIL lz_dig3 got %0d want 0", mcnt[3]); end
    tests_run++; if (mcnt[2] !== 0) begin tests_failed++; $display("FAIL lz_dig2 got %0d want 0", mcnt[2]); end
    tests_run++; if (mseg[1] !== 7'h24) begin tests_failed++; $display("FAIL lz_dig1 got %h want 24", mseg[1]); end
    tests_run++; if (mseg[0] !== 7'h01) begin tests_failed++; $display("FAIL lz_dig0 got %h want 01", mseg[0]); end
    nibbles = 16'h0000; load_now();
    next_frame();
    measure_frame(-1);
    tests_run++; if (mcnt[1] + mcnt[2] + mcnt[3] !== 0) begin tests_failed++; $display("FAIL lz_zero_upper got %0d want 0", mcnt[1] + mcnt[2] + mcnt[3]); end
    tests_run++; if (mcnt[0] !== 8) begin tests_failed++; $display("FAIL lz_zero_dig0 got %0d want 8", mcnt[0]); end
    lz_en = 1'b0;
  endtask

  task automatic test_pwm();
    int want [4];
    nibbles = 16'h4444; brightness = 3'd0; load_now();
    next_frame();
    want = '{1, 4, 4, 8};
    brightness = 3'd3; measure_frame(5);
    for (int d = 0; d < 4; d++) begin
      tests_run++; if (mcnt[d] !== 1) begin tests_failed++; $display("FAIL pwm0_dig%0d got %0d want 1", d, mcnt[d]); end
    end
    for (int f = 1; f < 4; f++) begin
      if (f == 2) brightness = 3'd7;
      measure_frame(f == 2 ? 5 : -1);
      for (int d = 0; d < 4; d++) begin
        tests_run++; if (mcnt[d] !== want[f]) begin tests_failed++; $display("FAIL pwm_f%0d_dig%0d got %0d want %0d", f, d, mcnt[d], want[f]); end
      end
    end
  endtask

  task automatic test_load_on_wrap();
    nibbles = 16'h3333; load_now();
    run_to(DIGITS * TICK_DIV - 1);
    nibbles = 16'h9999; load_now();
    tests_run++; if (pending !== 1'b1) begin tests_failed++; $display("FAIL wrapload_pending got %b want 1", pending); end
    measure_frame(-1);
    tests_run++; if (mseg[0] !== 7'h06) begin tests_failed++; $display("FAIL wrapload_old got %h want 06", mseg[0]); end
    tests_run++; if (pending !== 1'b0) begin tests_failed++; $display("FAIL wrapload_clear got %b want 0", pending); end
    measure_frame(-1);
    tests_run++; if (mseg[0] !== 7'h04) begin tests_failed++; $display("FAIL wrapload_new got %h want 04", mseg[0]); end
  endtask

  task automatic test_free_run();
    int pulses, last, bad_gap, bad_dig;
    logic [3:0] oh, want_dig;
    int p;
    blank_in = 4'b0100; nibbles = 16'h1234; brightness = 3'd7; load_now();
    blank_in = 4'b0000;
    next_frame();
    pulses = 0; last = -1; bad_gap = 0; bad_dig = 0;
    for (int k = 0; k < 4 * DIGITS * TICK_DIV; k++) begin
      p = fpos();
      step();
      oh = 4'b0001 << (p / TICK_DIV);
      want_dig = ((p / TICK_DIV) == 2) ? 4'hF : ~oh;
      if (dig !== want_dig) bad_dig++;
      if (frame_start === 1'b1) begin
        if (last >= 0 && k - last != DIGITS * TICK_DIV) bad_gap++;
        last = k;
        pulses++;
      end
    end
    tests_run++; if (pulses !== 4) begin tests_failed++; $display("FAIL fs_count got %0d want 4", pulses); end
    tests_run++; if (bad_gap !== 0) begin tests_failed++; $display("FAIL fs_spacing got %0d bad want 0", bad_gap); end
    tests_run++; if (bad_dig !== 0) begin tests_failed++; $display("FAIL scan_order got %0d bad want 0", bad_dig); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      load = ($urandom_range(0, 9) == 0);
      nibbles = 16'($urandom);
      dp_in = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      brightness = 3'($urandom);
      if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 3) == 0) nibbles[15:8] = 8'h00;
      step();
      load = 1'b0;
      tests_run++; if (seg !== e_seg) begin tests_failed++; $display("FAIL rnd_seg cyc %0d got %h want %h", k, seg, e_seg); end
      tests_run++; if (dp !== e_dp) begin tests_failed++; $display("FAIL rnd_dp cyc %0d got %b want %b", k, dp, e_dp); end
      tests_run++; if (dig !== e_dig) begin tests_failed++; $display("FAIL rnd_dig cyc %0d got %h want %h", k, dig, e_dig); end
      tests_run++; if (frame_start !== e_fs) begin tests_failed++; $display("FAIL rnd_fs cyc %0d got %b want %b", k, frame_start, e_fs); end
      tests_run++; if (pending !== e_pend) begin tests_failed++; $display("FAIL rnd_pending cyc %0d got %b want %b", k, pending, e_pend); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; load = 1'b0; nibbles = '0; dp_in = '0; blank_in = '0;
    lz_en = 1'b0; brightness = 3'd7;
    model_reset();
    test_reset();
    test_load_frame();
    test_lz();
    test_pwm();
    test_load_on_wrap();
    test_free_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
